mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one shared memory port.
// Each master has a one-entry pending slot; grants are round-robin with optional wait timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_rd,
  input  logic        m0_we,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_rd,
  input  logic        m1_we,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_rd,
  output logic        s_we,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        err_overrun,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1} state_t;

  state_t      state;
  logic        last;
  logic [15:0] cnt;
  logic        slot0_full, slot1_full;
  logic [31:0] slot0_a, slot0_d, slot1_a, slot1_d;
  logic        slot0_we, slot1_we;
  logic [31:0] cur_a, cur_d;

  logic        req0, req1, acc0, acc1, drop0, drop1;
  logic        cand0, cand1, grant0, grant1, issue;
  logic [31:0] iss_a, iss_d;
  logic        iss_we;
  logic        timeout_hit, done_wait, timed_out;

  assign req0  = m0_rd | m0_we;
  assign req1  = m1_rd | m1_we;
  // A strobe is accepted only if its slot is free and it is not already in flight.
  assign acc0  = req0 & ~slot0_full & (state != WAIT0);
  assign acc1  = req1 & ~slot1_full & (state != WAIT1);
  assign drop0 = req0 & ~acc0;
  assign drop1 = req1 & ~acc1;

  assign cand0  = ~rst & (state == IDLE) & (slot0_full | acc0);
  assign cand1  = ~rst & (state == IDLE) & (slot1_full | acc1);
  assign grant0 = cand0 & (~cand1 | last);
  assign grant1 = cand1 & (~cand0 | ~last);
  assign issue  = grant0 | grant1;

  assign timeout_hit = (TIMEOUT != 0) && (({16'd0, cnt} + 32'd1) == 32'(TIMEOUT));
  assign done_wait   = (state != IDLE) & (s_ready | timeout_hit);
  assign timed_out   = (state != IDLE) & ~s_ready & timeout_hit;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    iss_a  = 32'd0;
    iss_d  = 32'd0;
    iss_we = 1'b0;
    if (grant0) begin
      iss_a  = acc0 ? m0_a : slot0_a;
      iss_d  = acc0 ? m0_d : slot0_d;
      iss_we = acc0 ? m0_we : slot0_we;
    end else if (grant1) begin
      iss_a  = acc1 ? m1_a : slot1_a;
      iss_d  = acc1 ? m1_d : slot1_d;
      iss_we = acc1 ? m1_we : slot1_we;
    end
  end

  assign s_a      = issue ? iss_a : ((state != IDLE) ? cur_a : 32'd0);
  assign s_d      = issue ? iss_d : ((state != IDLE) ? cur_d : 32'd0);
  assign s_rd     = issue & ~iss_we;
  assign s_we     = issue & iss_we;
  assign m0_ready = (grant0 & s_ready) | ((state == WAIT0) & done_wait);
  assign m1_ready = (grant1 & s_ready) | ((state == WAIT1) & done_wait);
  assign m0_spo   = timed_out ? 32'hffff_ffff : s_spo;
  assign m1_spo   = timed_out ? 32'hffff_ffff : s_spo;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      cnt         <= 16'd0;
      slot0_full  <= 1'b0;
      slot1_full  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (drop0 | drop1) err_overrun <= 1'b1;
      if (grant0)     slot0_full <= 1'b0;
      else if (acc0)  slot0_full <= 1'b1;
      if (grant1)     slot1_full <= 1'b0;
      else if (acc1)  slot1_full <= 1'b1;

      case (state)
        IDLE: begin
          if (issue) begin
            cnt <= 16'd0;
            if (s_ready) last <= grant1;
            else         state <= grant0 ? WAIT0 : WAIT1;
          end
        end
        default: begin
          if (done_wait) begin
            state <= IDLE;
            last  <= (state == WAIT1);
            if (timed_out) err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // NOTE: payload registers carry no reset; their full flag or the FSM state gates every use.
  always_ff @(posedge clk) begin
    if (acc0 & ~grant0) begin
      slot0_a  <= m0_a;
      slot0_d  <= m0_d;
      slot0_we <= m0_we;
    end
    if (acc1 & ~grant1) begin
      slot1_a  <= m1_a;
      slot1_d  <= m1_d;
      slot1_we <= m1_we;
    end
    if (issue) begin
      cur_a <= iss_a;
      cur_d <= iss_d;
    end
  end

endmodule
